camera_capture: RTL and testbench

Front-end stage of the ISP pipeline. Samples an 8-bit parallel camera bus (VSYNC/HREF/PCLK/D[7:0]) in the system clock domain, pairs bytes into RGB565 pixels, and drives the `new_frame` / `data_valid` strobes and pixel word consumed by the `control` stage and the colour datapath. It also tracks pixel coordinates and flags malformed lines.

---
 rtl/isp_pkg.sv | 21 ++
 rtl/sync_edge.sv | 32 +++
 rtl/camera_capture.sv | 145 ++++++++++++++
 tb/tb_camera_capture.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared ISP types and default frame geometry.
// It is used by the capture front-end and the control stage.
package isp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    VSYNC,
    ACTIVE
  } capture_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int unsigned DEFAULT_WIDTH  = 640;
  localparam int unsigned DEFAULT_HEIGHT = 480;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by one delay stage.
// Edges are detected between the synchronised level and its delayed copy.
module sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/camera_capture.sv
// Camera bus front-end: samples VSYNC/HREF/PCLK/D in the clk domain and pairs bytes into RGB565.
// It also tracks pixel coordinates, counts completed frames and flags malformed lines.
module camera_capture
  import isp_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned HEIGHT = DEFAULT_HEIGHT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      capture_en,
  input  logic                      cam_pclk,
  input  logic                      cam_vsync,
  input  logic                      cam_href,
  input  logic [7:0]                cam_data,
  output logic                      new_frame,
  output logic                      data_valid,
  output logic [15:0]               pixel,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic                      frame_done,
  output logic                      line_error,
  output logic [15:0]               frame_count
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = $clog2(HEIGHT);

  capture_state_t state;

  logic pclk_rise, pclk_fall_unused, pclk_level_unused;
  logic vsync_rise, vsync_fall, vsync_level_unused;
  logic href, href_rise, href_fall;
  logic [7:0] data_s1, data_s2;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          row_full;
  logic          phase;
  logic [7:0]    hi_byte;
  logic          line_started;

  sync_edge #(.W(1)) u_pclk (
    .clk(clk), .reset(reset), .d(cam_pclk),
    .q(pclk_level_unused), .rise(pclk_rise), .fall(pclk_fall_unused)
  );

  sync_edge #(.W(1)) u_vsync (
    .clk(clk), .reset(reset), .d(cam_vsync),
    .q(vsync_level_unused), .rise(vsync_rise), .fall(vsync_fall)
  );

  sync_edge #(.W(1)) u_href (
    .clk(clk), .reset(reset), .d(cam_href),
    .q(href), .rise(href_rise), .fall(href_fall)
  );

  // Two stages, matching the synchronised pclk level the edge detector compares against.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      data_s1 <= cam_data;
      data_s2 <= data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      new_frame    <= 1'b0;
      data_valid   <= 1'b0;
      frame_done   <= 1'b0;
      line_error   <= 1'b0;
      pixel        <= '0;
      col          <= '0;
      row          <= '0;
      frame_count  <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      row_full     <= 1'b0;
      phase        <= 1'b0;
      hi_byte      <= '0;
      line_started <= 1'b0;
    end else begin
      new_frame  <= 1'b0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: if (capture_en) state <= ARM;
        ARM: if (vsync_rise) state <= VSYNC;
        VSYNC: begin
          if (vsync_fall) begin
            state        <= ACTIVE;
            new_frame    <= 1'b1;
            line_error   <= 1'b0;
            col_cnt      <= '0;
            row_cnt      <= '0;
            row_full     <= 1'b0;
            phase        <= 1'b0;
            line_started <= 1'b0;
          end
        end
        ACTIVE: begin
          if (href_rise) line_started <= 1'b1;
          // vsync has priority: a byte edge in the same cycle is discarded.
          if (vsync_rise) begin
            state <= capture_en ? VSYNC : IDLE;
            if (line_started) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
            end
          end else if (href_fall) begin
            if (phase || (col_cnt != CW'(WIDTH)) || row_full) line_error <= 1'b1;
            col_cnt <= '0;
            phase   <= 1'b0;
            // row saturates; row_full marks that the last legal line has already ended
            if (row_cnt == RW'(HEIGHT - 1)) row_full <= 1'b1;
            else                            row_cnt  <= row_cnt + RW'(1);
          end else if (pclk_rise && href) begin
            if (!phase) begin
              hi_byte <= data_s2;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (col_cnt < CW'(WIDTH)) begin
                data_valid <= 1'b1;
                pixel      <= {hi_byte, data_s2};
                col        <= col_cnt[XW-1:0];
                row        <= row_cnt;
                col_cnt    <= col_cnt + CW'(1);
              end else begin
                line_error <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Self-checking bench for camera_capture: a vector table of line shapes, hand-written corner sequences
// and random frames, all compared against a per-line reference model of the expected pixel stream.
module tb_camera_capture;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;

  logic clk = 1'b0;
  logic reset, capture_en, cam_pclk, cam_vsync, cam_href;
  logic [7:0] cam_data;
  logic new_frame, data_valid, frame_done, line_error;
  logic [15:0] pixel, frame_count;
  logic [$clog2(W)-1:0] col;
  logic [$clog2(H)-1:0] row;

  camera_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .new_frame(new_frame), .data_valid(data_valid), .pixel(pixel), .col(col), .row(row),
    .frame_done(frame_done), .line_error(line_error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pix;
    logic [7:0]  col;
    logic [7:0]  row;
  } px_t;

  px_t exp_q[$];
  px_t got_q[$];
  int unsigned got_idx = 0;
  int unsigned nf_cnt = 0, fd_cnt = 0, clash_cnt = 0;

  // Monitor: records strobes and pixels; all comparisons happen in the main thread.
  always @(negedge clk) begin
    if (data_valid) got_q.push_back(px_t'{pix: pixel, col: 8'(col), row: 8'(row)});
    if (new_frame) nf_cnt++;
    if (frame_done) fd_cnt++;
    if (data_valid && (new_frame || frame_done)) clash_cnt++;
  end

  int unsigned tests = 0, fails = 0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    cyc($urandom_range(2, 4));
    cam_pclk = 1'b1;
    cyc($urandom_range(2, 4));
    cam_pclk = 1'b0;
  endtask

  int unsigned line_idx;
  bit          exp_err;

  // Reference: pairs of bytes become pixels, at most W per line; row saturates at H-1;
  // a line that is not exactly 2*W bytes, or lies beyond H, flags an error.
  task automatic send_line(input int unsigned nb, input bit seq, input bit cap);
    logic [7:0] b[$];
    for (int unsigned i = 0; i < nb; i++) b.push_back(seq ? 8'(i + 1) : 8'($urandom));
    if (cap) begin
      for (int unsigned k = 0; k < nb / 2; k++)
        if (k < W)
          exp_q.push_back(px_t'{pix: {b[2*k], b[2*k+1]}, col: 8'(k),
                                row: 8'((line_idx < H) ? line_idx : H - 1)});
      if (nb != 2 * W || line_idx >= H) exp_err = 1'b1;
      line_idx++;
    end
    cam_href = 1'b1;
    cyc(3);
    foreach (b[i]) send_byte(b[i]);
    cyc(4);
    cam_href = 1'b0;
    cyc(4);
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    cyc(6);
    cam_vsync = 1'b0;
    cyc(6);
  endtask

  task automatic check_pixels(input string name);
    int unsigned n_got;
    #1;
    n_got = got_q.size() - got_idx;
    check({name, " pixel count"}, n_got, exp_q.size());
    for (int unsigned i = 0; i < n_got && i < exp_q.size(); i++)
      check({name, " pixel/col/row"}, got_q[got_idx + i], exp_q[i]);
    got_idx = got_q.size();
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string name);
    check({name, " new_frame"}, new_frame, 0);
    check({name, " data_valid"}, data_valid, 0);
    check({name, " frame_done"}, frame_done, 0);
    check({name, " line_error"}, line_error, 0);
    check({name, " pixel"}, pixel, 0);
    check({name, " col"}, col, 0);
    check({name, " row"}, row, 0);
    check({name, " frame_count"}, frame_count, 0);
  endtask

  typedef struct {
    int unsigned nl;
    int unsigned nb0, nb1, nb2;
    bit          seq;
    bit          err;
    int unsigned npix;
  } vec_t;

  vec_t        tbl[8];
  logic [15:0] exp_fc;
  int unsigned exp_fd, nf0, got0, nl;
  logic [7:0]  rb[6];

  initial begin
    tbl[0] = '{2, 8, 8, 0, 1'b1, 1'b0, 8};   // basic frame, bytes 0x01..0x08
    tbl[1] = '{2, 7, 8, 0, 1'b0, 1'b1, 7};   // odd byte count
    tbl[2] = '{2, 10, 8, 0, 1'b0, 1'b1, 8};  // overrun, extra pixel dropped
    tbl[3] = '{3, 8, 8, 8, 1'b0, 1'b1, 12};  // line beyond HEIGHT
    tbl[4] = '{1, 8, 0, 0, 1'b0, 1'b0, 4};   // short frame, good line
    tbl[5] = '{2, 2, 8, 0, 1'b0, 1'b1, 5};   // short line
    tbl[6] = '{2, 9, 8, 0, 1'b0, 1'b1, 8};   // full line plus dangling byte
    tbl[7] = '{2, 12, 8, 0, 1'b0, 1'b1, 8};  // two dropped pixels

    reset = 1'b1; capture_en = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0;
    cam_href = 1'b0; cam_data = '0;
    cyc(3);
    check_reset_values("reset");
    reset = 1'b0;
    capture_en = 1'b1;
    cyc(2);
    exp_fc = '0;
    exp_fd = 0;

    foreach (tbl[t]) begin
      nf0 = nf_cnt;
      vsync_pulse();
      if (t != 0) begin
        exp_fc++;
        exp_fd++;
      end
      check("tbl frame_count", frame_count, exp_fc);
      check("tbl frame_done count", fd_cnt, exp_fd);
      check("tbl new_frame count", nf_cnt - nf0, 1);
      check("tbl line_error cleared", line_error, 0);
      line_idx = 0; exp_err = 1'b0; got0 = got_q.size();
      send_line(tbl[t].nb0, tbl[t].seq, 1'b1);
      if (tbl[t].nl > 1) send_line(tbl[t].nb1, tbl[t].seq, 1'b1);
      if (tbl[t].nl > 2) send_line(tbl[t].nb2, tbl[t].seq, 1'b1);
      #1;
      check("tbl line_error", line_error, tbl[t].err);
      check("tbl data_valid count", got_q.size() - got0, tbl[t].npix);
      check_pixels("tbl");
    end

    // Drop capture_en: the open frame completes and the block goes idle.
    capture_en = 1'b0;
    nf0 = nf_cnt;
    vsync_pulse();
    exp_fc++; exp_fd++;
    check("disable frame_count", frame_count, exp_fc);
    check("disable frame_done count", fd_cnt, exp_fd);
    check("disable new_frame count", nf_cnt - nf0, 0);

    // Re-enable mid-line: nothing is captured until a full vsync rise/fall.
    send_line(8, 1'b0, 1'b0);
    cam_href = 1'b1;
    cyc(3);
    for (int unsigned i = 0; i < 3; i++) send_byte(8'($urandom));
    capture_en = 1'b1;
    for (int unsigned i = 0; i < 5; i++) send_byte(8'($urandom));
    cyc(4); cam_href = 1'b0; cyc(4);
    send_line(8, 1'b0, 1'b0);
    check_pixels("mid-frame idle");
    nf0 = nf_cnt;
    vsync_pulse();
    check("mid-frame new_frame count", nf_cnt - nf0, 1);
    check("mid-frame frame_count", frame_count, exp_fc);
    line_idx = 0; exp_err = 1'b0;
    send_line(8, 1'b0, 1'b1);
    send_line(8, 1'b0, 1'b1);
    #1 check("mid-frame line_error", line_error, 0);
    check_pixels("mid-frame");

    for (int unsigned f = 0; f < 4; f++) begin
      vsync_pulse();
      exp_fc++; exp_fd++;
      check("rand frame_count", frame_count, exp_fc);
      check("rand line_error cleared", line_error, 0);
      line_idx = 0; exp_err = 1'b0;
      nl = $urandom_range(1, 3);
      for (int unsigned l = 0; l < nl; l++) send_line($urandom_range(0, 12), 1'b0, 1'b1);
      #1 check("rand line_error", line_error, exp_err);
      check_pixels("rand");
    end

    // Reset after three pixels of the second line.
    vsync_pulse();
    exp_fc++; exp_fd++;
    check("pre-reset frame_count", frame_count, exp_fc);
    line_idx = 0; exp_err = 1'b0;
    send_line(5, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 6; i++) rb[i] = 8'($urandom);
    for (int unsigned k = 0; k < 3; k++)
      exp_q.push_back(px_t'{pix: {rb[2*k], rb[2*k+1]}, col: 8'(k), row: 8'(1)});
    cam_href = 1'b1;
    cyc(3);
    foreach (rb[i]) send_byte(rb[i]);
    cyc(4);
    #1 check("pre-reset line_error", line_error, 1);
    check_pixels("pre-reset");
    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    check_reset_values("mid-line reset");
    reset = 1'b0;
    cam_href = 1'b0;
    exp_fc = '0;
    cyc(6);
    nf0 = nf_cnt;
    vsync_pulse();
    check("post-reset new_frame count", nf_cnt - nf0, 1);
    check("post-reset frame_done count", fd_cnt, exp_fd);
    line_idx = 0; exp_err = 1'b0;
    send_line(8, 1'b1, 1'b1);
    send_line(8, 1'b1, 1'b1);
    check_pixels("post-reset");

    // Preloaded counter wraps to zero on the next completed frame.
    force dut.frame_count = 16'hFFFF;
    cyc(1);
    release dut.frame_count;
    exp_fc = 16'hFFFF;
    vsync_pulse();
    exp_fc++; exp_fd++;
    check("frame_count wrap", frame_count, exp_fc);
    check("wrap frame_done count", fd_cnt, exp_fd);

    check("strobe overlap count", clash_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
